// File: rtl/lstm_weight_fetch_ctrl.sv
// rtl/lstm_weight_fetch_ctrl.sv - LSTM gate weight memory load/fetch sequencer with 2-entry skid FIFO
module lstm_wf_skid_fifo #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

module lstm_weight_fetch_ctrl #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_ADDR  = 9,
    parameter int CNT_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RAM_ADDR-1:0]  base_addr,
    input  logic [CNT_W-1:0]     n_rows,
    input  logic [CNT_W-1:0]     n_cols,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 ld_valid,
    input  logic [RAM_ADDR-1:0]  ld_addr,
    input  logic [RAM_WIDTH-1:0] ld_data,
    output logic                 ld_ready,
    output logic                 mem_ce,
    output logic                 mem_we,
    output logic [RAM_ADDR-1:0]  mem_addr,
    output logic [RAM_WIDTH-1:0] mem_wdata,
    input  logic [RAM_WIDTH-1:0] mem_rdata,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [RAM_WIDTH-1:0] w_data,
    output logic                 w_last_col,
    output logic                 w_last_row
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [RAM_ADDR-1:0] base_q;
    logic [RAM_ADDR-1:0] issue_idx;
    logic [CNT_W-1:0]    rows_q;
    logic [CNT_W-1:0]    cols_q;
    logic [CNT_W-1:0]    row_cnt;
    logic [CNT_W-1:0]    col_cnt;

    logic inflight;
    logic inflight_lc;
    logic inflight_lr;

    logic [1:0]           fifo_count;
    logic [2:0]           occ;
    logic [RAM_WIDTH+1:0] fifo_head;
    logic                 head_lc;
    logic                 head_lr;

    logic start_ok;
    logic start_bad;
    logic ld_fire;
    logic flush;
    logic pop;
    logic room;
    logic issue;
    logic col_wrap;
    logic row_last;
    logic last_issue;
    logic final_pop;

    assign start_ok  = (state == IDLE) && start && (n_rows != '0) && (n_cols != '0);
    assign start_bad = (state == IDLE) && start && ((n_rows == '0) || (n_cols == '0));
    assign ld_ready  = (state == IDLE) && !start;
    assign ld_fire   = ld_valid && ld_ready;
    assign busy      = (state != IDLE);
    assign flush     = abort && (state != IDLE);

    assign {w_data, head_lc, head_lr} = fifo_head;
    assign w_last_col = w_valid && head_lc;
    assign w_last_row = w_valid && head_lr;
    assign pop        = w_valid && w_ready;
    assign final_pop  = pop && head_lc && head_lr;

    // A read is only issued when a FIFO slot is guaranteed for its data next cycle.
    assign occ        = {1'b0, fifo_count} + {2'b00, inflight};
    assign room       = (occ < 3'd2) || ((occ == 3'd2) && pop);
    assign issue      = (state == RUN) && !abort && room;

    assign col_wrap   = (col_cnt == cols_q - CNT_W'(1));
    assign row_last   = (row_cnt == rows_q - CNT_W'(1));
    assign last_issue = col_wrap && row_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (issue && last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort || final_pop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_fire) begin
            mem_ce    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
        end else if (issue) begin
            mem_ce    = 1'b1;
            mem_addr  = base_q + issue_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            issue_idx <= '0;
        end else if (start_ok) begin
            base_q    <= base_addr;
            rows_q    <= n_rows;
            cols_q    <= n_cols;
            row_cnt   <= '0;
            col_cnt   <= '0;
            issue_idx <= '0;
        end else if (flush) begin
            row_cnt   <= '0;
            col_cnt   <= '0;
            issue_idx <= '0;
        end else if (issue) begin
            issue_idx <= issue_idx + RAM_ADDR'(1);
            if (col_wrap) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + CNT_W'(1);
            end else begin
                col_cnt <= col_cnt + CNT_W'(1);
            end
        end
    end

    // Row/column flags ride alongside the read so they enter the FIFO with its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_lc <= 1'b0;
            inflight_lr <= 1'b0;
        end else if (flush) begin
            inflight    <= 1'b0;
            inflight_lc <= 1'b0;
            inflight_lr <= 1'b0;
        end else begin
            inflight    <= issue;
            inflight_lc <= col_wrap;
            inflight_lr <= row_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (state == DRAIN) && final_pop && !abort;
            err  <= start_bad;
        end
    end

    lstm_wf_skid_fifo #(
        .W(RAM_WIDTH + 2)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (inflight),
        .push_data ({mem_rdata, inflight_lc, inflight_lr}),
        .pop       (pop),
        .out_valid (w_valid),
        .out_data  (fifo_head),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_lstm_weight_fetch_ctrl.sv
// tb/tb_lstm_weight_fetch_ctrl.sv - randomized self-checking bench for lstm_weight_fetch_ctrl
module tb_lstm_weight_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [8:0]  base_addr;
    logic [8:0]  n_rows;
    logic [8:0]  n_cols;
    logic        busy;
    logic        done;
    logic        err;
    logic        ld_valid;
    logic [8:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        mem_ce;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        w_valid;
    logic        w_ready = 1'b0;
    logic [15:0] w_data;
    logic        w_last_col;
    logic        w_last_row;

    lstm_weight_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .n_rows(n_rows), .n_cols(n_cols),
        .busy(busy), .done(done), .err(err),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_last_col(w_last_col), .w_last_row(w_last_row)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] ram [512];
    always @(posedge clk) begin
        if (mem_ce && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_ce && !mem_we) mem_rdata <= ram[mem_addr];
        else mem_rdata <= 16'($urandom);
    end

    int w_mode = 0;
    int wr_phase = 0;
    always @(posedge clk) begin
        #1;
        case (w_mode)
            0: w_ready = 1'b1;
            1: begin w_ready = (wr_phase % 3 == 0); wr_phase++; end
            default: w_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    typedef struct packed {
        logic [15:0] data;
        logic        lc;
        logic        lr;
    } word_t;

    logic [15:0] ref_mem [512];
    word_t       exp_q[$];
    logic [8:0]  addr_q[$];
    bit          exp_busy = 0;
    bit          exp_done = 0;
    bit          exp_err = 0;
    bit          prev_stall = 0;
    bit          prev_abort = 0;
    logic [17:0] prev_word = '0;
    int          outstanding = 0;
    int          errors = 0;
    int          checks = 0;

    int          first_issue_cyc = -1, first_valid_cyc = -1, last_hs_cyc = -1;
    int          done_cyc = -1, err_cyc = -1, hs_count = 0, lc_mask = 0, lr_mask = 0;
    logic [15:0] hs_data[$];
    logic [8:0]  iss_addr[$];

    string       lit_name [256];
    logic [31:0] lit_act [256];
    logic [31:0] lit_exp [256];
    int          lit_wr = 0;
    int          lit_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Literal expectations from the stimulus process are queued here and judged by the monitor.
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (lit_wr < 256) begin
            lit_name[lit_wr] = name;
            lit_act[lit_wr]  = act;
            lit_exp[lit_wr]  = exp;
            lit_wr++;
        end
    endtask

    always @(negedge clk) begin : mon
        word_t      e;
        logic [8:0] a;
        bit         ab, hs, fin;
        int         nr, nc;
        while (lit_rd < lit_wr) begin
            chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
        if (!rst_n) begin
            exp_busy = 0; exp_done = 0; exp_err = 0;
            exp_q.delete(); addr_q.delete();
            outstanding = 0; prev_stall = 0; prev_abort = 0;
        end else begin
            ab  = abort && exp_busy;
            hs  = w_valid && w_ready;
            fin = 0;
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("ld_ready", ld_ready, !exp_busy && !start);
            if (!exp_busy) chk("w_valid_idle", w_valid, 0);
            if (prev_abort) chk("w_valid_after_abort", w_valid, 0);
            if (prev_stall) begin
                chk("hold_valid", w_valid, 1);
                chk("hold_word", {w_data, w_last_col, w_last_row}, prev_word);
            end
            if (ld_valid && !exp_busy && !start) begin
                chk("ld_ce_we", {mem_ce, mem_we}, 2'b11);
                chk("ld_addr", mem_addr, ld_addr);
                chk("ld_wdata", mem_wdata, ld_data);
            end else if (!exp_busy) begin
                chk("mem_idle", {mem_ce, mem_we}, 2'b00);
            end else begin
                chk("mem_we_busy", mem_we, 0);
            end
            if (exp_busy && mem_ce && !mem_we && !ab) begin
                if (addr_q.size() == 0) chk("read_extra", mem_addr, 32'hffffffff);
                else chk("read_addr", mem_addr, addr_q.pop_front());
                iss_addr.push_back(mem_addr);
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                outstanding++;
            end
            if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hs && !ab) begin
                if (exp_q.size() == 0) begin
                    chk("word_extra", {w_data, w_last_col, w_last_row}, 32'hffffffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {w_data, w_last_col, w_last_row}, e);
                    fin = (exp_q.size() == 0);
                end
                hs_data.push_back(w_data);
                if (w_last_col) lc_mask |= (1 << hs_count);
                if (w_last_row) lr_mask |= (1 << hs_count);
                hs_count++;
                last_hs_cyc = cyc;
                outstanding--;
            end
            checks++;
            if (outstanding > 2) begin
                errors++;
                $display("FAIL outstanding: got %0d expected at most 2 at cycle %0d", outstanding, cyc);
            end
            if (done) done_cyc = cyc;
            if (err) err_cyc = cyc;

            exp_err    = !exp_busy && start && (n_rows == 0 || n_cols == 0);
            exp_done   = fin && !ab;
            prev_stall = w_valid && !w_ready && !ab;
            prev_word  = {w_data, w_last_col, w_last_row};
            prev_abort = ab;
            if (ab) begin
                exp_q.delete(); addr_q.delete();
                outstanding = 0;
                exp_busy = 0;
            end else if (fin) begin
                exp_busy = 0;
            end else if (!exp_busy && start) begin
                first_issue_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1;
                done_cyc = -1; err_cyc = -1; hs_count = 0; lc_mask = 0; lr_mask = 0;
                hs_data.delete(); iss_addr.delete();
                if (n_rows != 0 && n_cols != 0) begin
                    nr = n_rows;
                    nc = n_cols;
                    for (int i = 0; i < nr * nc; i++) begin
                        a = 9'(base_addr + 9'(i));
                        addr_q.push_back(a);
                        exp_q.push_back(word_t'({ref_mem[a], (i % nc) == nc - 1, (i / nc) == nr - 1}));
                    end
                    exp_busy = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [8:0] a, input logic [15:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        ref_mem[a] = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic do_start(input int b, input int r, input int c, output int c0);
        base_addr = 9'(b); n_rows = 9'(r); n_cols = 9'(c);
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        base_addr = 9'($urandom); n_rows = 9'($urandom); n_cols = 9'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (exp_busy && i < budget) begin
            tick();
            i++;
        end
        if (exp_busy) lit("timeout", 0, 1);
        repeat (2) tick();
    endtask

    initial begin
        int c0, b, r, c;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; n_rows = '0; n_cols = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) tick();
        lit("rst_busy", busy, 0);
        lit("rst_done", done, 0);
        lit("rst_err", err, 0);
        lit("rst_w_valid", w_valid, 0);
        lit("rst_last", {w_last_col, w_last_row}, 0);
        lit("rst_w_data", w_data, 0);
        lit("rst_mem", {mem_ce, mem_we, mem_addr, mem_wdata}, 0);
        lit("rst_ld_ready", ld_ready, 1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 512; i++) load(9'(i), 16'($urandom));

        w_mode = 0;
        tick();
        do_start(10, 2, 3, c0);
        wait_idle(100);
        lit("fetch_first_read", first_issue_cyc - c0, 1);
        lit("fetch_first_valid", first_valid_cyc - c0, 3);
        lit("fetch_last_hs", last_hs_cyc - c0, 8);
        lit("fetch_done", done_cyc - c0, 9);
        for (int i = 0; i < 6; i++) lit("fetch_addr", iss_addr[i], 10 + i);
        lit("fetch_last_col", lc_mask, 6'b100100);
        lit("fetch_last_row", lr_mask, 6'b111000);

        w_mode = 1;
        do_start(10, 2, 3, c0);
        wait_idle(100);
        lit("bp_count", hs_count, 6);
        for (int i = 0; i < 6; i++) lit("bp_data", hs_data[i], ref_mem[10 + i]);

        w_mode = 0;
        do_start(510, 1, 4, c0);
        wait_idle(100);
        lit("wrap_a0", iss_addr[0], 510);
        lit("wrap_a1", iss_addr[1], 511);
        lit("wrap_a2", iss_addr[2], 0);
        lit("wrap_a3", iss_addr[3], 1);

        load(20, 16'hABCD);
        do_start(20, 1, 1, c0);
        wait_idle(100);
        lit("load_word", hs_data[0], 16'hABCD);
        lit("load_done", done_cyc - c0, 4);

        do_start(5, 2, 0, c0);
        repeat (3) tick();
        lit("err_pulse", err_cyc - c0, 1);

        ld_valid = 1'b1; ld_addr = 30; ld_data = ~ref_mem[30];
        do_start(30, 1, 2, c0);
        ld_valid = 1'b0;
        base_addr = 100; n_rows = 1; n_cols = 1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(100);
        lit("coll_count", hs_count, 2);
        lit("coll_w0", hs_data[0], ref_mem[30]);
        lit("coll_w1", hs_data[1], ref_mem[31]);

        do_start(40, 4, 4, c0);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        lit("abort_busy", busy, 0);
        lit("abort_valid", w_valid, 0);
        repeat (5) tick();
        lit("abort_no_done", done_cyc, 32'hffffffff);
        do_start(60, 2, 2, c0);
        wait_idle(100);
        lit("restart_addr0", iss_addr[0], 60);
        lit("restart_count", hs_count, 4);
        lit("restart_done", done_cyc - c0, 7);

        w_mode = 2;
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 3)) load(9'($urandom), 16'($urandom));
            b = $urandom_range(0, 511);
            r = $urandom_range(0, 4);
            c = $urandom_range(1, 4);
            do_start(b, r, c, c0);
            if (r != 0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 6)) tick();
                if (exp_busy) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                end
            end
            wait_idle(400);
        end

        do_start(100, 3, 3, c0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        lit("midrst_busy", busy, 0);
        lit("midrst_valid", w_valid, 0);
        lit("midrst_mem_ce", mem_ce, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lstm_weight_fetch_ctrl.md
# lstm_weight_fetch_ctrl

Sequencer that owns the single-port weight memory (1-cycle read latency, 1 port shared for load and fetch) of one LSTM gate. It accepts a host/loader write stream while idle and, on `start`, streams an `n_rows × n_cols` weight block in row-major order from `base_addr` to the MAC array through a valid/ready interface. A 2-entry skid FIFO absorbs the memory read latency so that backpressure never loses a word.

## Interface
- `RAM_WIDTH`, 16, weight word width
- `RAM_ADDR`, 9, memory address width
- `CNT_W`, 9, width of row/column counts

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin fetch; sampled only in IDLE
- `abort`  in  1  synchronous flush to IDLE
- `base_addr`  in  RAM_ADDR  first weight address; latched on start
- `n_rows`, `n_cols`  in  CNT_W  block size; latched on start; must be ≥1
- `busy`  out  1  fetch in progress
- `done`  out  1  1-cycle pulse after last word handshake
- `err`  out  1  1-cycle pulse on start with a zero count
- `ld_valid`  in  1  loader write request
- `ld_addr`  in  RAM_ADDR  loader address
- `ld_data`  in  RAM_WIDTH  loader data
- `ld_ready`  out  1  = IDLE & ~start
- `mem_ce`, `mem_we`  out  1  memory enable / write enable
- `mem_addr`  out  RAM_ADDR  memory address
- `mem_wdata`  out  RAM_WIDTH  memory write data
- `mem_rdata`  in  RAM_WIDTH  memory read data, valid the cycle after a read ce
- `w_valid`  out  1  weight word available
- `w_ready`  in  1  consumer accepts
- `w_data`  out  RAM_WIDTH  weight word
- `w_last_col`  out  1  word is last of its row
- `w_last_row`  out  1  word is in the last row (with `w_last_col` = final word)

## Operation
- States: IDLE, RUN (issuing reads), DRAIN (all reads issued, FIFO non-empty). done is a registered flag raised in the cycle the FSM returns to IDLE.
- IDLE + `start` + both counts nonzero → RUN. Latch base, counts; clear row/col counters and issue counter.
- IDLE + `start` + any count zero → `err` pulse next cycle; stay IDLE.
- `start` while busy is ignored. Count/base input changes after the start cycle are ignored.
- Load path: when `ld_valid & ld_ready`, drive combinationally `mem_ce=mem_we=1`, `mem_addr=ld_addr`, `mem_wdata=ld_data`. `start` in the same cycle wins; `ld_ready` is low.
- Read issue in RUN: `mem_ce=1`, `mem_we=0` when `fifo_count + inflight − pop < 2`, with `pop = w_valid & w_ready`.
- Address is `base + issue_idx`, modulo 2^RAM_ADDR, so it wraps from max to 0.
- Col counter increments per issue and wraps at `n_cols−1`, which increments the row counter. Flags travel with each word through the FIFO.
- `inflight` is registered and set to the issue of the previous cycle. When inflight=1, `mem_rdata` is pushed into the FIFO. `mem_rdata` is never captured otherwise, including after a load write.
- After issuing the word at row `n_rows−1`, col `n_cols−1` → DRAIN. The handshake of the final word → IDLE, with `done`=1 for that next cycle.
- `abort` (any state except IDLE) → IDLE next cycle. FIFO, inflight and counters are cleared, no `done`, `w_valid` drops next cycle.
- Outputs held stable while `w_valid & ~w_ready`.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `done`, `err`, `w_valid`, `w_last_col`, `w_last_row` all 0
  - `w_data` 0, `mem_ce` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0
  - FIFO empty
  - `ld_ready` = ~`start`
- Start in cycle 0:
  - `busy` is 1 from cycle 1.
  - First read is in cycle 1.
  - `mem_rdata` is valid in cycle 2.
  - First `w_valid` is in cycle 3.
- With `w_ready` held high, throughput is 1 word/cycle. The total for N words is the final handshake in cycle N+2, with `done` in cycle N+3 and `busy` low in cycle N+3.
- The FIFO never exceeds 2 entries, and no read is issued without a reserved slot.
- `rst_n` deassertion mid-run is not special. Assertion at any time forces reset values immediately.

## Test plan
- Fetch: `start` with base 10, 2 rows × 3 cols, `w_ready`=1 → addresses 10..15 issued in cycles 1–6. `w_last_col` on words 3 and 6. `w_last_row` on words 4–6. `done` in cycle 9.
- Backpressure: same as the fetch case but `w_ready` toggles 1,0,0,1,… → words still delivered in order 10..15 with none lost or duplicated. At most 2 reads are ever outstanding or buffered.
- Address wrap: base 510, 1 row × 4 cols → addresses 510, 511, 0, 1.
- Load: write 0xABCD to address 20 via the loader, then fetch base 20, 1×1 → `w_data` 0xABCD and `done` pulses.
- Error and collision: `start` with `n_cols`=0 → `err` pulse, `busy` stays 0. `start` and `ld_valid` in the same cycle → no write occurs, and the fetch begins.
- Abort: `abort` in the 3rd cycle of a 4×4 fetch → `w_valid` and `busy` are 0 next cycle, `done` never asserts. A new `start` afterwards runs cleanly from its base.
